mem_stage: RTL



---
 rtl/mem_stage_pkg.sv | 28 ++
 rtl/mem_load_align.sv | 30 +++
 rtl/mem_stage.sv | 87 ++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// Shared bus widths, ld_ctrl bit positions and the captured EX->MEM bus layout
// for the memory-access stage.
package mem_stage_pkg;

    localparam int unsigned ExRegBusLen  = 141;
    localparam int unsigned MemRegBusLen = 70;
    localparam int unsigned MemBypassLen = 38;

    // Bit positions inside ld_ctrl = {ld_w, ld_h, ld_hu, ld_b, ld_bu}
    localparam int unsigned LdW  = 4;
    localparam int unsigned LdH  = 3;
    localparam int unsigned LdHu = 2;
    localparam int unsigned LdB  = 1;
    localparam int unsigned LdBu = 0;

    typedef struct packed {
        logic        mul;
        logic [31:0] mul_result;
        logic [31:0] ex_result;
        logic [31:0] rkd_value;
        logic [4:0]  ld_ctrl;
        logic        rf_we;
        logic        res_from_mem;
        logic [4:0]  rf_waddr;
        logic [31:0] pc;
    } ex_bus_t;

endpackage

// File: rtl/mem_load_align.sv
// Extracts the addressed byte/halfword/word from a 32-bit read word and
// sign- or zero-extends it according to the one-hot load control.
module mem_load_align
    import mem_stage_pkg::*;
(
    input  logic [4:0]  ld_ctrl,
    input  logic [1:0]  off,
    input  logic [31:0] rdata,
    output logic [31:0] load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = rdata[{off, 3'b000} +: 8];
    assign half_sel = off[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        load_data = rdata;
        unique case (1'b1)
            ld_ctrl[LdB]:  load_data = {{24{byte_sel[7]}}, byte_sel};
            ld_ctrl[LdBu]: load_data = {24'h0, byte_sel};
            ld_ctrl[LdH]:  load_data = {{16{half_sel[15]}}, half_sel};
            ld_ctrl[LdHu]: load_data = {16'h0, half_sel};
            ld_ctrl[LdW]:  load_data = rdata;
            default:       load_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: EX->MEM register, load alignment, write-back
// select and a one-entry hold buffer for SRAM/multiplier data under WB stalls.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    EXreg_valid,
    input  logic [ExRegBusLen-1:0]  EXreg_bus,
    input  logic                    EX_ready_go,
    input  logic                    WB_allow_in,
    input  logic [31:0]             data_sram_rdata,
    input  logic [31:0]             mul_result,
    output logic                    MEM_allow_in,
    output logic                    MEM_ready_go,
    output logic                    MEMreg_valid,
    output logic [MemRegBusLen-1:0] MEMreg_bus,
    output logic [MemBypassLen-1:0] MEM_bypass_bus
);

    ex_bus_t     ex_in;
    ex_bus_t     ex_q;
    logic        valid_q;
    logic        first_q;
    logic        hold_vld_q;
    logic [31:0] hold_rdata_q;
    logic [31:0] hold_mul_q;

    logic        accept;
    logic [31:0] raw_rdata;
    logic [31:0] mul_src;
    logic [31:0] load_data;
    logic [31:0] rf_wdata;

    assign ex_in        = ex_bus_t'(EXreg_bus);
    assign accept       = EXreg_valid & EX_ready_go;
    assign MEM_allow_in = ~valid_q | WB_allow_in;
    assign MEM_ready_go = 1'b1;
    assign MEMreg_valid = valid_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q      <= 1'b0;
            first_q      <= 1'b0;
            hold_vld_q   <= 1'b0;
            hold_rdata_q <= 32'h0;
            hold_mul_q   <= 32'h0;
            ex_q         <= '0;
        end else begin
            if (MEM_allow_in) begin
                valid_q    <= accept;
                first_q    <= accept;
                ex_q       <= ex_in;
                hold_vld_q <= 1'b0;
            end else begin
                first_q <= 1'b0;
            end
            // Live SRAM/multiplier data disappear after the first cycle; keep a copy.
            if (valid_q & first_q & ~WB_allow_in) begin
                hold_rdata_q <= data_sram_rdata;
                hold_mul_q   <= mul_result;
                hold_vld_q   <= 1'b1;
            end
        end
    end

    assign raw_rdata = first_q ? data_sram_rdata : hold_rdata_q;
    assign mul_src   = first_q ? mul_result      : hold_mul_q;

    mem_load_align u_load_align (
        .ld_ctrl   (ex_q.ld_ctrl),
        .off       (ex_q.ex_result[1:0]),
        .rdata     (raw_rdata),
        .load_data (load_data)
    );

    assign rf_wdata = ex_q.res_from_mem ? load_data :
                      (ex_q.mul ? mul_src : ex_q.ex_result);

    assign MEMreg_bus     = {ex_q.rf_we, ex_q.rf_waddr, rf_wdata, ex_q.pc};
    assign MEM_bypass_bus = {ex_q.rf_waddr, ex_q.rf_we & valid_q, rf_wdata};

    // Captured mul_result is stale by design and rkd_value has no consumer here.
    logic unused_fields;
    assign unused_fields = ^{ex_q.mul_result, ex_q.rkd_value, hold_vld_q};

endmodule
